// File: rtl/mem_arb.sv
// mem_arb: single-port memory arbiter shared by instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_arb #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       any_req;
    logic       grant_dm;

    assign any_req = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
    logic last_owner;

    // On a tie the port that did not win last time goes first.
    assign grant_dm = dm_req & (~if_req | ~last_owner);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            last_owner <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_owner <= grant_dm;
        end
    end
`else
    assign grant_dm = dm_req;
`endif

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            owner     <= 1'b0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state  <= ACCESS;
                        owner  <= grant_dm;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        mem_we <= grant_dm & dm_we;
                        cnt    <= CNT_LOAD;
                        if (grant_dm) begin
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end else begin
                            mem_addr  <= if_addr;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 3'd0) begin
                        state  <= ACK;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner) begin
                            dm_ack <= 1'b1;
                        end else begin
                            if_ack <= 1'b1;
                        end
                        // mem_we still holds the granted direction here.
                        if (!mem_we) begin
                            if (owner) begin
                                dm_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed self-checking bench for mem_arb.
// Main instance at MEM_LAT=2, plus fetch-only instances at MEM_LAT=1 and 8.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;

    logic        x1_req, x1_ack, x1_dack, x1_en, x1_we, x1_busy, x1_own;
    logic [31:0] x1_rdata, x1_drd, x1_wd;
    logic [15:0] x1_addr;
    logic        x8_req, x8_ack, x8_dack, x8_en, x8_we, x8_busy, x8_own;
    logic [31:0] x8_rdata, x8_drd, x8_wd;
    logic [15:0] x8_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        mem_rdata = {16'hC0DE, mem_addr};
        case (mem_addr)
            16'h0010: mem_rdata = 32'hDEADBEEF;
            16'h0080: mem_rdata = 32'hA5A5A5A5;
            default:  mem_rdata = {16'hC0DE, mem_addr};
        endcase
    end

    mem_arb #(.AW(16), .DW(32), .MEM_LAT(2)) dut (
        .clk(clk), .rst_f(rst_f),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_arb #(.AW(16), .DW(32), .MEM_LAT(1)) u1 (
        .clk(clk), .rst_f(rst_f),
        .if_req(x1_req), .if_addr(16'h0100), .if_ack(x1_ack), .if_rdata(x1_rdata),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0000), .dm_wdata(32'h0),
        .dm_ack(x1_dack), .dm_rdata(x1_drd),
        .mem_en(x1_en), .mem_we(x1_we), .mem_addr(x1_addr), .mem_wdata(x1_wd),
        .mem_rdata({16'hC0DE, x1_addr}), .busy(x1_busy), .owner(x1_own)
    );

    mem_arb #(.AW(16), .DW(32), .MEM_LAT(8)) u8 (
        .clk(clk), .rst_f(rst_f),
        .if_req(x8_req), .if_addr(16'h0200), .if_ack(x8_ack), .if_rdata(x8_rdata),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0000), .dm_wdata(32'h0),
        .dm_ack(x8_dack), .dm_rdata(x8_drd),
        .mem_en(x8_en), .mem_we(x8_we), .mem_addr(x8_addr), .mem_wdata(x8_wd),
        .mem_rdata({16'hC0DE, x8_addr}), .busy(x8_busy), .owner(x8_own)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int got;
        int icnt;
        int a1;
        int a8;
        logic [5:0] seq;
        logic [5:0] exp_seq;
        int exp_icnt;

        rst_f  = 1'b0;
        if_req = 1'b0; if_addr = 16'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 16'h0; dm_wdata = 32'h0;
        x1_req = 1'b0; x8_req = 1'b0;
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_acks", {30'b0, if_ack, dm_ack}, 32'd0);
        chk("rst_owner", {31'b0, owner}, 32'd0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        rst_f = 1'b1;
        tick();

        // Single fetch read
        if_addr = 16'h0010; if_req = 1'b1;
        tick();
        chk("f_busy", {31'b0, busy}, 32'd1);
        chk("f_en0", {31'b0, mem_en}, 32'd1);
        chk("f_we0", {31'b0, mem_we}, 32'd0);
        chk("f_owner", {31'b0, owner}, 32'd0);
        chk("f_addr", {16'b0, mem_addr}, 32'h0010);
        tick();
        chk("f_en1", {31'b0, mem_en}, 32'd1);
        chk("f_ack_early", {31'b0, if_ack}, 32'd0);
        tick();
        chk("f_ack", {31'b0, if_ack}, 32'd1);
        chk("f_en_off", {31'b0, mem_en}, 32'd0);
        chk("f_rdata", if_rdata, 32'hDEADBEEF);
        chk("f_dm_ack", {31'b0, dm_ack}, 32'd0);
        if_req = 1'b0;
        tick();
        chk("f_ack_pulse", {31'b0, if_ack}, 32'd0);
        chk("f_idle", {31'b0, busy}, 32'd0);

        // Simultaneous: data write wins, fetch follows
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0040; dm_wdata = 32'h12345678;
        if_req = 1'b1; if_addr = 16'h0010;
        tick();
        chk("s_owner_d", {31'b0, owner}, 32'd1);
        chk("s_we0", {31'b0, mem_we}, 32'd1);
        chk("s_addr_d", {16'b0, mem_addr}, 32'h0040);
        chk("s_wdata", mem_wdata, 32'h12345678);
        tick();
        chk("s_we1", {31'b0, mem_we}, 32'd1);
        tick();
        chk("s_dm_ack", {31'b0, dm_ack}, 32'd1);
        chk("s_if_ack_0", {31'b0, if_ack}, 32'd0);
        chk("s_we_off", {31'b0, mem_we}, 32'd0);
        dm_req = 1'b0;
        tick();
        chk("s_gap_idle", {31'b0, busy}, 32'd0);
        tick();
        chk("s_owner_f", {31'b0, owner}, 32'd0);
        chk("s_addr_f", {16'b0, mem_addr}, 32'h0010);
        chk("s_wdata_hold", mem_wdata, 32'h12345678);
        chk("s_f_we", {31'b0, mem_we}, 32'd0);
        tick();
        tick();
        chk("s_if_ack", {31'b0, if_ack}, 32'd1);
        chk("s_if_rdata", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        tick();
        chk("s_done", {31'b0, busy}, 32'd0);

        // dm_rdata unaffected by a later write
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0080;
        tick();
        tick();
        tick();
        chk("i_ack_rd", {31'b0, dm_ack}, 32'd1);
        chk("i_rdata", dm_rdata, 32'hA5A5A5A5);
        dm_we = 1'b1; dm_wdata = 32'h0;
        tick();
        tick();
        chk("i_wr_we", {31'b0, mem_we}, 32'd1);
        chk("i_wr_addr", {16'b0, mem_addr}, 32'h0080);
        tick();
        tick();
        chk("i_ack_wr", {31'b0, dm_ack}, 32'd1);
        chk("i_rdata_kept", dm_rdata, 32'hA5A5A5A5);
        chk("i_if_rdata_kept", if_rdata, 32'hDEADBEEF);
        dm_req = 1'b0;
        tick();

        // Reset during the first ACCESS cycle of a write
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0040; dm_wdata = 32'h55;
        if_req = 1'b1; if_addr = 16'h0010;
        tick();
        chk("r_we_pre", {31'b0, mem_we}, 32'd1);
        rst_f = 1'b0;
        #1;
        chk("r_en_async", {31'b0, mem_en}, 32'd0);
        chk("r_we_async", {31'b0, mem_we}, 32'd0);
        chk("r_busy_async", {31'b0, busy}, 32'd0);
        tick();
        chk("r_no_ack", {30'b0, if_ack, dm_ack}, 32'd0);
        rst_f = 1'b1;

        // Both ports requesting continuously for six accesses
        n = 0; got = 0; icnt = 0; seq = '0;
        while (got < 6 && n < 40) begin
            tick();
            n++;
            if (n == 1) begin
                chk("c_first_owner", {31'b0, owner}, 32'd1);
                chk("c_first_busy", {31'b0, busy}, 32'd1);
            end
            if (dm_ack || if_ack) begin
                seq[got] = dm_ack;
                got++;
                if (if_ack) icnt++;
            end
        end
        chk("c_count", got, 32'd6);
        chk("c_cycles", n, 32'd23);
`ifdef MEM_ARB_RR_EN
        exp_seq = 6'b010101;
        exp_icnt = 3;
`else
        exp_seq = 6'b111111;
        exp_icnt = 0;
`endif
        chk("c_order", {26'b0, seq}, {26'b0, exp_seq});
        chk("c_if_acks", icnt, exp_icnt);
        dm_req = 1'b0; if_req = 1'b0;
        tick();
        tick();
        tick();

        // Latency sweep: four back-to-back fetches at MEM_LAT 1 and 8
        x1_req = 1'b1; x8_req = 1'b1;
        n = 0; a1 = 0; a8 = 0;
        while ((a1 < 4 || a8 < 4) && n < 60) begin
            tick();
            n++;
            if (x1_ack) begin
                a1++;
                if (a1 == 1) begin
                    chk("l1_first", n, 32'd2);
                    chk("l1_rdata", x1_rdata, 32'hC0DE0100);
                end
                if (a1 == 4) begin
                    chk("l1_fourth", n, 32'd11);
                    x1_req = 1'b0;
                end
            end
            if (x8_ack) begin
                a8++;
                if (a8 == 1) begin
                    chk("l8_first", n, 32'd9);
                    chk("l8_rdata", x8_rdata, 32'hC0DE0200);
                end
                if (a8 == 4) begin
                    chk("l8_fourth", n, 32'd39);
                    x8_req = 1'b0;
                end
            end
        end
        chk("l1_acks", a1, 32'd4);
        chk("l8_acks", a8, 32'd4);
        tick();
        tick();
        chk("l_idle", {30'b0, x1_busy, x8_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter that shares one single-port unified memory between the instruction-fetch path (IR load) and the data path (LOD/STR) of the SISC processor. It sits between the `ctrl`-sequenced datapath and the memory macro. It grants one requester at a time, drives the memory for a fixed access latency, and returns read data with a one-cycle acknowledge.

## Interface

Parameters:
- `AW`, 16: address width.
- `DW`, 32: data width.
- `MEM_LAT`, 2: memory access cycles, legal range 1..8. Internal counter is 3 bits wide and is loaded with `MEM_LAT-1`.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst_f`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch read request.
- `if_addr`  in  AW  fetch address.
- `if_ack`  out  1  fetch done, one-cycle pulse.
- `if_rdata`  out  DW  fetch read-data holding register.
- `dm_req`  in  1  data request.
- `dm_we`  in  1  data request is a write.
- `dm_addr`  in  AW  data address.
- `dm_wdata`  in  DW  write data.
- `dm_ack`  out  1  data done, one-cycle pulse.
- `dm_rdata`  out  DW  data read-data holding register.
- `mem_en`  out  1  memory enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid in the final access cycle.
- `busy`  out  1  access in progress.
- `owner`  out  1  current grant: 0 = fetch, 1 = data. Meaningful only while `busy` is high.

## Operation

- States:
  - IDLE: arbitrate.
  - ACCESS: drive memory, count down.
  - ACK: pulse ack.
- IDLE → ACCESS on any request sampled high.
  - Latch address, `we` and wdata of the winner into `mem_*`.
  - Set `owner`.
  - Load counter with `MEM_LAT-1`.
- Arbitration is fixed priority, data over fetch.
- ACCESS behaviour:
  - `mem_en=1` for the whole state.
  - `mem_we` equals the latched `we`; always 0 for fetch.
  - Counter decrements each edge.
  - At an edge with counter==0: go to ACK. On a read, capture `mem_rdata` into the owner's rdata register.
- ACK → IDLE unconditionally.
  - Owner's ack is high for exactly this cycle.
  - `mem_en` and `mem_we` are 0.
- `mem_addr` and `mem_wdata` hold their last value until the next grant.
- Rdata registers change only on reads by their own port. Writes never alter `dm_rdata`.
- `busy` is 1 in ACCESS and ACK.
- Request rule: the requester holds `req` and its qualifiers stable until it sees ack. It deasserts `req` at the edge ending the ack cycle. A `req` still high in the following IDLE cycle is a new request.
- Qualifier changes during ACCESS are ignored, because they are latched at grant.
- Reset values (asynchronous, immediate): state IDLE, counter 0, `owner` 0, all acks/`mem_en`/`mem_we`/`busy` 0, `mem_addr`/`mem_wdata`/`if_rdata`/`dm_rdata` 0, `last_owner` 0.
- Reset mid-access: the access is aborted with no ack. A write in progress is truncated (memory content is undefined for that address). After release, pending requests are arbitrated afresh.

## Timing

- Accept edge P0 (IDLE, `req` high).
- Ack is high in the cycle following edge P0+`MEM_LAT`.
- Read data is valid in the rdata register from that same cycle.
- One access occupies `MEM_LAT`+2 cycles (IDLE + ACCESS×`MEM_LAT` + ACK).
- Back-to-back throughput from one port is one access per `MEM_LAT`+2 cycles.
- Simultaneous requests: the loser waits. It is granted at the IDLE following the winner's ACK, with no further penalty.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration

- `MEM_ARB_RR_EN` undefined: fixed priority, data over fetch. Under continuous data requests, fetch can starve.
- `MEM_ARB_RR_EN` defined: round-robin.
  - A `last_owner` register updates at each grant.
  - On simultaneous requests, the port that is not `last_owner` wins.
  - A single requester is always granted.
  - `last_owner` resets to 0, so the first tie goes to data in both builds.

## Test plan

- Fetch read, `MEM_LAT`=2, `if_addr`=0x0010, memory returns 0xDEADBEEF → `mem_en` high 2 cycles, `if_ack` pulses once at P0+2, `if_rdata`=0xDEADBEEF, `dm_ack` stays 0.
- Simultaneous `if_req` and `dm_req` (write, `dm_addr`=0x0040, `dm_wdata`=0x12345678), fixed build → data served first with `mem_we` high 2 cycles and `dm_ack`; fetch granted next IDLE; both complete within 8 cycles.
- `MEM_ARB_RR_EN` build, both ports requesting continuously for 6 accesses → grant order D,I,D,I,D,I. Same stimulus in fixed build → D only, `if_ack` never asserted.
- `rst_f` low during the first ACCESS cycle of a write → `mem_en`/`mem_we`/`busy` drop without waiting for a clock edge; no ack. After release with both `req` held, data is granted at the first edge.
- `dm_rdata` integrity: read 0xA5A5A5A5, then write 0x0 to the same address → `dm_rdata` stays 0xA5A5A5A5 until the next data read.
- Latency sweep `MEM_LAT`=1 and 8 → ack exactly `MEM_LAT` edges after accept; 4 back-to-back fetches take 4×(`MEM_LAT`+2) cycles.
